// File: rtl/mem_responder_if.sv
// Request/response bundle between the core's memory port and mem_responder.
interface mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;

    modport master (
        output mem_read, mem_write, addr, wdata, size,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata, size,
        output rdata, ready, busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// Unified I/D memory slave: wait-stated B/H/W loads and stores with sign/zero extension.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned H/W completes with err=1, rdata=0, no write.
module mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);
    localparam int         LP_DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] LP_WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] { S_IDLE, S_WAIT, S_DONE } state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_op_wr;
    logic [ADDR_WIDTH+1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [2:0]            r_size;
    logic [31:0]           r_rdata;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_err;
    logic [31:0]           r_mem [LP_DEPTH];

    logic                  w_acc_wr;
    logic [ADDR_WIDTH+1:0] w_acc_addr;
    logic [2:0]            w_acc_size;
    logic [ADDR_WIDTH-1:0] w_acc_idx;
    logic                  w_misalign;
    logic [31:0]           w_load;
    logic                  w_unused;

    function automatic logic [31:0] load_ext(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [2:0]  sz);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (sz)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

    // Unsigned store sizes behave as their signed counterparts; undefined sizes act as W.
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] d,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  sz);
        logic [31:0] m;
        m = old;
        case (sz)
            3'b000, 3'b100: begin
                case (lane)
                    2'd0:    m[7:0]   = d[7:0];
                    2'd1:    m[15:8]  = d[7:0];
                    2'd2:    m[23:16] = d[7:0];
                    default: m[31:24] = d[7:0];
                endcase
            end
            3'b001, 3'b101: begin
                if (lane[1]) m[31:16] = d[15:0];
                else         m[15:0]  = d[15:0];
            end
            default: m = d;
        endcase
        return m;
    endfunction

`ifdef MEM_MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [1:0] lane, input logic [2:0] sz);
        case (sz)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return lane[0];
            default:        return (lane != 2'b00);
        endcase
    endfunction
`endif

    // In IDLE the access is described by the live bus (zero-wait case), otherwise by the capture.
    always_comb begin
        w_acc_wr   = r_op_wr;
        w_acc_addr = r_addr;
        w_acc_size = r_size;
        if (r_state == S_IDLE) begin
            w_acc_wr   = bus.mem_write;
            w_acc_addr = bus.addr[ADDR_WIDTH+1:0];
            w_acc_size = bus.size;
        end
    end

    assign w_acc_idx = w_acc_addr[ADDR_WIDTH+1:2];

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misalign = misaligned(w_acc_addr[1:0], w_acc_size);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_load   = w_misalign ? 32'd0 : load_ext(r_mem[w_acc_idx], w_acc_addr[1:0], w_acc_size);
    assign w_unused = ^bus.addr[31:ADDR_WIDTH+2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.mem_read || bus.mem_write) begin
                        r_op_wr <= bus.mem_write;
                        r_addr  <= w_acc_addr;
                        r_wdata <= bus.wdata;
                        r_size  <= bus.size;
                        r_busy  <= 1'b1;
                        if (LP_WS == 4'd0) begin
                            r_state <= S_DONE;
                            r_ready <= 1'b1;
                            r_err   <= w_misalign;
                            if (!w_acc_wr) r_rdata <= w_load;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= LP_WS;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_DONE;
                        r_ready <= 1'b1;
                        r_err   <= w_misalign;
                        if (!w_acc_wr) r_rdata <= w_load;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Commit on the edge leaving DONE so a following capture already sees the new word.
    always_ff @(posedge clk) begin
        if (!rst && r_state == S_DONE && r_op_wr && !w_misalign)
            r_mem[r_addr[ADDR_WIDTH+1:2]] <= store_merge(r_mem[r_addr[ADDR_WIDTH+1:2]],
                                                         r_wdata, r_addr[1:0], r_size);
    end

    assign bus.rdata = r_rdata;
    assign bus.ready = r_ready;
    assign bus.busy  = r_busy;
    assign bus.err   = r_err;
endmodule
